// File: rtl/bnn_mem0_arbiter.sv
// ----------------------------------------------------------------------------
// bnn_mem0_arbiter
//
// Purpose:
//   Arbitrates one single-port MEM0 between a host and a BNN core. The host
//   owns the memory while idle. An iFRAME_GO request starts an inference:
//   the core gets a 1-cycle start pulse and then owns the memory until it
//   writes its class index to RESULT_ADDR. That write is forwarded to memory,
//   and its low nibble is captured as oRESULT.
//
//   Optional watchdog (macro BNN_ARB_WATCHDOG_EN): a 20-bit counter limits
//   the RUN phase to TIMEOUT_CYCLES cycles. On expiry the FSM passes through
//   a 1-cycle ERR state (oERR pulse) and returns to idle. Without the macro,
//   RUN waits indefinitely and oERR is tied low.
//
// Parameters:
//   RESULT_ADDR     MEM0 word address the core writes the class index to
//   TIMEOUT_CYCLES  watchdog limit for RUN (used only with the watchdog)
//
// Ports:
//   iCLK, iRSTn (async, active-low), iCLR (sync clear to IDLE)
//   Host  : iHOST_REQ/WE/ADDR/WDATA, oHOST_GNT, oHOST_RDATA, oHOST_RVALID
//   Core  : iFRAME_GO, iBNN_ADDR/WDATA/RD_EN/WR_EN, oBNN_RDATA, oBNN_START
//   Memory: oMEM_ADDR/WDATA/RD_EN/WR_EN, iMEM_RDATA (1-cycle read latency)
//   Status: oBUSY, oDONE, oERR, oRESULT, oRESULT_VALID
// ----------------------------------------------------------------------------
module bnn_mem0_arbiter #(
  parameter logic [5:0]  RESULT_ADDR    = 6'd36,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd600000
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iCLR,
  // host side
  input  logic        iHOST_REQ,
  input  logic        iHOST_WE,
  input  logic [5:0]  iHOST_ADDR,
  input  logic [27:0] iHOST_WDATA,
  output logic        oHOST_GNT,
  output logic [27:0] oHOST_RDATA,
  output logic        oHOST_RVALID,
  // inference control
  input  logic        iFRAME_GO,
  // core side
  input  logic [5:0]  iBNN_ADDR,
  input  logic [27:0] iBNN_WDATA,
  input  logic        iBNN_RD_EN,
  input  logic        iBNN_WR_EN,
  output logic [27:0] oBNN_RDATA,
  output logic        oBNN_START,
  // memory side
  output logic [5:0]  oMEM_ADDR,
  output logic [27:0] oMEM_WDATA,
  output logic        oMEM_RD_EN,
  output logic        oMEM_WR_EN,
  input  logic [27:0] iMEM_RDATA,
  // status
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic [3:0]  oRESULT,
  output logic        oRESULT_VALID
);

  localparam int ADDR_W = 6;
  localparam int DATA_W = 28;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
`ifdef BNN_ARB_WATCHDOG_EN
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
`else
    S_DONE  = 3'd3
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              host_gnt;
  logic              go_accept;
  logic              result_hit;
  logic              result_q;
  logic [3:0]        result_idx_q;
  logic              host_rd_vld_p1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd_en;
  logic              mem_wr_en;

  // The host is only ever granted while idle; a grant is same-cycle.
  assign host_gnt   = (state_q == S_IDLE) && iHOST_REQ;
  assign go_accept  = (state_q == S_IDLE) && iFRAME_GO;
  // A result write only counts while the core owns the memory.
  assign result_hit = (state_q == S_RUN) && iBNN_WR_EN && (iBNN_ADDR == RESULT_ADDR);

`ifdef BNN_ARB_WATCHDOG_EN
  logic [19:0] wd_cnt_q;
  logic        wd_expire;

  // Counter value k is seen in the k-th RUN cycle (0-based), so the last
  // permitted RUN cycle is TIMEOUT_CYCLES-1. A result write on that same
  // cycle still wins over the timeout.
  assign wd_expire = (state_q == S_RUN) && !result_hit &&
                     (wd_cnt_q == (TIMEOUT_CYCLES - 20'd1));

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wd_cnt_q <= '0;
    end else if (iCLR) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_START) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      wd_cnt_q <= wd_cnt_q + 20'd1;
    end
  end
`else
  // TIMEOUT_CYCLES has no function without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iFRAME_GO) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (result_hit) begin
          state_d = S_DONE;
        end
`ifdef BNN_ARB_WATCHDOG_EN
        else if (wd_expire) begin
          state_d = S_ERR;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
`ifdef BNN_ARB_WATCHDOG_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port ownership: host in IDLE, core in RUN, nobody otherwise.
  // When the core asserts both enables the write wins and the read is dropped.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_addr  = iHOST_ADDR;
        mem_wdata = iHOST_WDATA;
        mem_rd_en = iHOST_REQ && !iHOST_WE;
        mem_wr_en = iHOST_REQ && iHOST_WE;
      end
      S_RUN: begin
        mem_addr  = iBNN_ADDR;
        mem_wdata = iBNN_WDATA;
        mem_rd_en = iBNN_RD_EN && !iBNN_WR_EN;
        mem_wr_en = iBNN_WR_EN;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
      end
    endcase
  end

  // ---- stage p0 -> p1: host read issue to read-data return ----
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q        <= S_IDLE;
      host_rd_vld_p1 <= 1'b0;
      result_idx_q   <= '0;
      result_q       <= 1'b0;
    end else if (iCLR) begin
      state_q        <= S_IDLE;
      host_rd_vld_p1 <= 1'b0;
      result_idx_q   <= '0;
      result_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      host_rd_vld_p1 <= host_gnt && !iHOST_WE;
      if (result_hit) begin
        result_idx_q <= iBNN_WDATA[3:0];
      end
      // A new frame invalidates the previous result until it completes.
      if (go_accept) begin
        result_q <= 1'b0;
      end else if (result_hit) begin
        result_q <= 1'b1;
      end
`ifdef BNN_ARB_WATCHDOG_EN
      else if (wd_expire) begin
        result_q <= 1'b0;
      end
`endif
    end
  end

  assign oHOST_GNT     = host_gnt;
  assign oHOST_RVALID  = host_rd_vld_p1;
  assign oHOST_RDATA   = host_rd_vld_p1 ? iMEM_RDATA : '0;

  assign oBNN_RDATA    = iMEM_RDATA;
  assign oBNN_START    = (state_q == S_START);

  assign oMEM_ADDR     = mem_addr;
  assign oMEM_WDATA    = mem_wdata;
  assign oMEM_RD_EN    = mem_rd_en;
  assign oMEM_WR_EN    = mem_wr_en;

  assign oBUSY         = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DONE);
  assign oDONE         = (state_q == S_DONE);
`ifdef BNN_ARB_WATCHDOG_EN
  assign oERR          = (state_q == S_ERR);
`else
  assign oERR          = 1'b0;
`endif
  assign oRESULT       = result_idx_q;
  assign oRESULT_VALID = result_q;

endmodule

// File: tb/tb_bnn_mem0_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bnn_mem0_arbiter
//
// Directed stimulus for bnn_mem0_arbiter (RESULT_ADDR=36, TIMEOUT_CYCLES=10).
// The environment provides a 64-word memory with 1-cycle read latency. A
// behavioural model of the arbitration rules predicts every output. A compare
// process checks the outputs against that model on each falling edge, and the
// stimulus sequence adds hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_bnn_mem0_arbiter;

`ifdef BNN_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int TO = 10;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        host_req, host_we;
  logic [5:0]  host_addr;
  logic [27:0] host_wdata;
  logic        host_gnt;
  logic [27:0] host_rdata;
  logic        host_rvalid;
  logic        frame_go;
  logic [5:0]  bnn_addr;
  logic [27:0] bnn_wdata;
  logic        bnn_rd, bnn_wr;
  logic [27:0] bnn_rdata;
  logic        bnn_start;
  logic [5:0]  mem_addr;
  logic [27:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [27:0] mem_rdata;
  logic        busy, done, err, result_valid;
  logic [3:0]  result;

  int n_cmp  = 0;
  int n_fail = 0;

  bnn_mem0_arbiter #(
    .RESULT_ADDR   (6'd36),
    .TIMEOUT_CYCLES(20'd10)
  ) dut (
    .iCLK         (clk),
    .iRSTn        (rstn),
    .iCLR         (clr),
    .iHOST_REQ    (host_req),
    .iHOST_WE     (host_we),
    .iHOST_ADDR   (host_addr),
    .iHOST_WDATA  (host_wdata),
    .oHOST_GNT    (host_gnt),
    .oHOST_RDATA  (host_rdata),
    .oHOST_RVALID (host_rvalid),
    .iFRAME_GO    (frame_go),
    .iBNN_ADDR    (bnn_addr),
    .iBNN_WDATA   (bnn_wdata),
    .iBNN_RD_EN   (bnn_rd),
    .iBNN_WR_EN   (bnn_wr),
    .oBNN_RDATA   (bnn_rdata),
    .oBNN_START   (bnn_start),
    .oMEM_ADDR    (mem_addr),
    .oMEM_WDATA   (mem_wdata),
    .oMEM_RD_EN   (mem_rd),
    .oMEM_WR_EN   (mem_wr),
    .iMEM_RDATA   (mem_rdata),
    .oBUSY        (busy),
    .oDONE        (done),
    .oERR         (err),
    .oRESULT      (result),
    .oRESULT_VALID(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory (driven by the DUT memory ports).
  logic [27:0] emem [64];
  always @(posedge clk) begin
    if (mem_wr) emem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= emem[mem_addr];
  end

  // Behavioural model: tracks what the memory must hold and where the
  // inference stands (go just accepted, RUN cycle count, done/err cycle).
  logic [27:0] mmem [64];
  bit          m_go_seen;
  int          m_run_cyc;
  bit          m_done, m_err;
  logic [3:0]  m_res;
  bit          m_rv;
  bit          m_rvalid;
  logic [27:0] m_rdata;
  bit          u_idle, u_run, u_hit, u_to;
  int          u_next_run;

  always @(posedge clk) begin
    if (!rstn || clr) begin
      m_go_seen = 0; m_run_cyc = -1; m_done = 0; m_err = 0;
      m_res = 4'd0; m_rv = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      u_idle = !m_go_seen && (m_run_cyc < 0) && !m_done && !m_err;
      u_run  = (m_run_cyc >= 0);
      u_hit  = u_run && bnn_wr && (bnn_addr == 6'd36);
      u_to   = WD && u_run && !u_hit && (m_run_cyc == TO - 1);
      m_rvalid = u_idle && host_req && !host_we;
      m_rdata  = mmem[host_addr];
      if (u_idle && host_req && host_we) mmem[host_addr] = host_wdata;
      if (u_run && bnn_wr) mmem[bnn_addr] = bnn_wdata;
      if (u_hit) begin m_res = bnn_wdata[3:0]; m_rv = 1; end
      if (u_to) m_rv = 0;
      if (u_idle && frame_go) m_rv = 0;
      if (u_hit || u_to)  u_next_run = -1;
      else if (u_run)     u_next_run = m_run_cyc + 1;
      else if (m_go_seen) u_next_run = 0;
      else                u_next_run = -1;
      m_done    = u_hit;
      m_err     = u_to;
      m_go_seen = u_idle && frame_go;
      m_run_cyc = u_next_run;
    end
  end

  // Per-cycle compare against the model.
  bit e_idle, e_run, e_wr, e_rd;
  always @(negedge clk) begin
    e_idle = !rstn || (!m_go_seen && (m_run_cyc < 0) && !m_done && !m_err);
    e_run  = rstn && (m_run_cyc >= 0);
    e_wr   = e_idle ? (host_req && host_we) : (e_run ? bnn_wr : 1'b0);
    e_rd   = e_idle ? (host_req && !host_we) : (e_run ? (bnn_rd && !bnn_wr) : 1'b0);
    chk("m_gnt",      32'(host_gnt),     32'(e_idle && host_req));
    chk("m_start",    32'(bnn_start),    32'(rstn && m_go_seen));
    chk("m_busy",     32'(busy),         32'(rstn && (m_go_seen || m_run_cyc >= 0 || m_done)));
    chk("m_done",     32'(done),         32'(rstn && m_done));
    chk("m_err",      32'(err),          32'(rstn && m_err));
    chk("m_result",   32'(result),       rstn ? 32'(m_res) : 32'd0);
    chk("m_res_vld",  32'(result_valid), 32'(rstn && m_rv));
    chk("m_rvalid",   32'(host_rvalid),  32'(rstn && m_rvalid));
    if (rstn && m_rvalid) chk("m_rdata", 32'(host_rdata), 32'(m_rdata));
    chk("m_mem_wr",   32'(mem_wr),       32'(e_wr));
    chk("m_mem_rd",   32'(mem_rd),       32'(e_rd));
    if (e_wr || e_rd) chk("m_mem_addr", 32'(mem_addr), e_idle ? 32'(host_addr) : 32'(bnn_addr));
    if (e_wr) chk("m_mem_wdata", 32'(mem_wdata), e_idle ? 32'(host_wdata) : 32'(bnn_wdata));
    chk("m_bnn_rdata", 32'(bnn_rdata), 32'(mem_rdata));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_err;
  bit busy_late;

  initial begin
    for (int i = 0; i < 64; i++) begin emem[i] = '0; mmem[i] = '0; end
    mem_rdata = '0;
    rstn = 1'b0; clr = 1'b0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    frame_go = 0; bnn_addr = '0; bnn_wdata = '0; bnn_rd = 0; bnn_wr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    tick(); rstn = 1'b1;

    // Host write 5 <= 0ABCDEF then read it back.
    tick(); host_req = 1; host_we = 1; host_addr = 6'd5; host_wdata = 28'h0ABCDEF;
    @(negedge clk); chk("wr_gnt", 32'(host_gnt), 1); chk("wr_mem_we", 32'(mem_wr), 1);
    tick(); host_we = 0;
    @(negedge clk); chk("rd_gnt", 32'(host_gnt), 1); chk("rd_rvalid_early", 32'(host_rvalid), 0);
    tick(); host_req = 0;
    @(negedge clk); chk("rd_rvalid", 32'(host_rvalid), 1); chk("rd_rdata", 32'(host_rdata), 32'h0ABCDEF);

    // Core write to the result address while idle must not land anywhere.
    tick(); bnn_wr = 1; bnn_addr = 6'd36; bnn_wdata = 28'd5;
    @(negedge clk); chk("idle_core_mem_we", 32'(mem_wr), 0);
    tick(); bnn_wr = 0; host_req = 1; host_addr = 6'd36;
    tick(); host_req = 0;
    @(negedge clk); chk("idle_core_rdata", 32'(host_rdata), 0); chk("idle_core_result", 32'(result), 0);

    // Frame go together with a host read.
    tick(); frame_go = 1; host_req = 1; host_addr = 6'd5;
    @(negedge clk); chk("go_rd_gnt", 32'(host_gnt), 1);
    tick(); frame_go = 0; host_addr = 6'd10;   // host keeps requesting: must stall
    @(negedge clk);
    chk("start_pulse", 32'(bnn_start), 1); chk("start_busy", 32'(busy), 1);
    chk("go_rd_rvalid", 32'(host_rvalid), 1); chk("go_rd_rdata", 32'(host_rdata), 32'h0ABCDEF);
    chk("start_gnt", 32'(host_gnt), 0);
    tick(); bnn_rd = 1; bnn_addr = 6'd5;
    @(negedge clk); chk("run_start_low", 32'(bnn_start), 0); chk("run_gnt", 32'(host_gnt), 0);
    chk("run_mem_rd", 32'(mem_rd), 1);
    tick(); bnn_wr = 1; bnn_addr = 6'd10; bnn_wdata = 28'h1234567;
    @(negedge clk); chk("prio_wr", 32'(mem_wr), 1); chk("prio_rd", 32'(mem_rd), 0);
    chk("core_rdata", 32'(bnn_rdata), 32'h0ABCDEF);
    tick(); bnn_rd = 0; bnn_addr = 6'd36; bnn_wdata = 28'h0000007;
    @(negedge clk); chk("res_wr_fwd", 32'(mem_wr), 1); chk("res_wr_addr", 32'(mem_addr), 36);
    tick(); bnn_wr = 0;
    @(negedge clk); chk("done_pulse", 32'(done), 1); chk("done_result", 32'(result), 7);
    chk("done_rv", 32'(result_valid), 1); chk("done_mem_we", 32'(mem_wr), 0);
    tick();
    @(negedge clk); chk("post_done_busy", 32'(done | busy), 0); chk("stall_gnt", 32'(host_gnt), 1);
    tick(); host_req = 0;
    @(negedge clk); chk("stall_rdata", 32'(host_rdata), 32'h1234567);

    // Second frame: go held high, core enables in START, sync clear mid-RUN.
    tick(); frame_go = 1;
    @(negedge clk); chk("rv_held", 32'(result_valid), 1);
    tick(); bnn_wr = 1; bnn_addr = 6'd20; bnn_wdata = 28'd3;
    @(negedge clk); chk("rv_cleared", 32'(result_valid), 0); chk("start_mem_we", 32'(mem_wr), 0);
    tick(); bnn_wr = 0;
    @(negedge clk); chk("go_ignored", 32'(bnn_start), 0);
    tick(); frame_go = 0; clr = 1;
    @(negedge clk); chk("pre_clr_busy", 32'(busy), 1);
    tick(); clr = 0;
    @(negedge clk); chk("clr_busy", 32'(busy), 0); chk("clr_result", 32'(result), 0);

    // Third frame, result 0xB.
    tick(); frame_go = 1;
    tick(); frame_go = 0;
    tick(); bnn_wr = 1; bnn_addr = 6'd36; bnn_wdata = 28'h00000AB;
    tick(); bnn_wr = 0;
    @(negedge clk); chk("frame3_result", 32'(result), 32'hB);
    tick();

    // Asynchronous reset in the middle of RUN.
    tick(); frame_go = 1;
    tick(); frame_go = 0;
    tick();
    tick(); rstn = 0;
    #1;
    chk("arst_busy", 32'(busy), 0); chk("arst_result", 32'(result), 0);
    chk("arst_rv", 32'(result_valid), 0); chk("arst_start", 32'(bnn_start), 0);
    tick(); rstn = 1;

    // No result write: watchdog ERR, or indefinite RUN without it.
    first_err = -1; busy_late = 0;
    tick(); frame_go = 1;
    for (int i = 1; i <= 20; i++) begin
      tick(); if (i == 1) frame_go = 0;
      @(negedge clk);
      if (err && first_err < 0) first_err = i;
      if (i == 14) busy_late = busy;
    end
`ifdef BNN_ARB_WATCHDOG_EN
    chk("wd_err_cycle", 32'(first_err), 32'd12);
    chk("wd_idle_after", 32'(busy_late), 0);
`else
    chk("no_wd_err", 32'(first_err), 32'hFFFFFFFF);
    chk("no_wd_busy", 32'(busy_late), 1);
`endif
    tick(); clr = 1;
    tick(); clr = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
